// File: rtl/mmio_console.sv
// mmio_console: memory-mapped transmit console for a single-cycle CPU.
// Four word registers at BASE_ADDR: TXDATA, STATUS, CYCLE, CONTROL.
// Stores to TXDATA feed a circular TX FIFO drained over a valid/ready port.
// Optional free-running CYCLE counter: define MMIO_CONSOLE_CYCLE_EN.
module mmio_console #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_7F00,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dmAddress,
    input  logic        dmWriteEnabled,
    input  logic [31:0] dmWriteInput,
    output logic [31:0] dmReadResult,
    output logic        mmioHit,
    output logic        txValid,
    output logic [7:0]  txData,
    input  logic        txReady
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        OFF_TXDATA  = 2'd0,
        OFF_STATUS  = 2'd1,
        OFF_CYCLE   = 2'd2,
        OFF_CONTROL = 2'd3
    } reg_off_e;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          drain_q, drain_d;

    reg_off_e      off;
    logic          wr_tx, wr_ctrl;
    logic          full, empty, pop, push_ok, drop;
    logic [7:0]    count8;
    logic [31:0]   cycle_val;
    logic          unused_bits;

    assign mmioHit = (dmAddress[31:4] == BASE_ADDR[31:4]);
    assign off     = reg_off_e'(dmAddress[3:2]);
    assign wr_tx   = mmioHit && dmWriteEnabled && (off == OFF_TXDATA);
    assign wr_ctrl = mmioHit && dmWriteEnabled && (off == OFF_CONTROL);

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign txValid = !reset && !empty && drain_q;
    assign txData  = mem_q[rd_ptr_q];
    assign pop     = txValid && txReady;
    // A push into a full FIFO is only accepted when the head leaves on the same edge.
    assign push_ok = wr_tx && (!full || pop);
    assign drop    = wr_tx && full && !pop;
    assign count8  = 8'(count_q);

    assign unused_bits = ^{dmAddress[1:0], dmWriteInput[31:8]};

`ifdef MMIO_CONSOLE_CYCLE_EN
    logic        wr_cyc;
    logic [31:0] cycle_q, cycle_d;

    assign wr_cyc  = mmioHit && dmWriteEnabled && (off == OFF_CYCLE);
    assign cycle_d = wr_cyc ? dmWriteInput : cycle_q + 32'd1;

    // Cycle counter: free-running, loadable by a CYCLE store.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) cycle_q <= '0;
        else       cycle_q <= cycle_d;
    end

    assign cycle_val = cycle_q;
`else
    assign cycle_val = '0;
`endif

    // Next-state logic for FIFO pointers, occupancy and control flags.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drain_d    = drain_q;

        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;

        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (wr_ctrl) begin
            drain_d = dmWriteInput[0];
            if (dmWriteInput[1]) overflow_d = 1'b0;
        end
        // Dropped push is evaluated last so it wins over a same-cycle clear.
        if (drop) overflow_d = 1'b1;
    end

    // Control/state registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drain_q    <= 1'b1;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drain_q    <= drain_d;
        end
    end

    // FIFO storage write; contents need no reset.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= dmWriteInput[7:0];
    end

    // Combinational load data for the addressed register.
    always_comb begin
        dmReadResult = '0;
        if (mmioHit) begin
            case (off)
                OFF_TXDATA:  dmReadResult = '0;
                OFF_STATUS:  dmReadResult = {16'b0, count8, 4'b0, drain_q, overflow_q, empty, full};
                OFF_CYCLE:   dmReadResult = cycle_val;
                OFF_CONTROL: dmReadResult = {31'b0, drain_q};
                default:     dmReadResult = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_console.sv
// Testbench for mmio_console: scoreboard of transmitted bytes plus register checks.
module tb_mmio_console;

    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] dmAddress;
    logic        dmWriteEnabled;
    logic [31:0] dmWriteInput;
    logic [31:0] dmReadResult;
    logic        mmioHit;
    logic        txValid;
    logic [7:0]  txData;
    logic        txReady;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [7:0]  sb [$];

    mmio_console #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (8)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .dmAddress      (dmAddress),
        .dmWriteEnabled (dmWriteEnabled),
        .dmWriteInput   (dmWriteInput),
        .dmReadResult   (dmReadResult),
        .mmioHit        (mmioHit),
        .txValid        (txValid),
        .txData         (txData),
        .txReady        (txReady)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic store(input logic [1:0] off, input logic [31:0] data);
        dmAddress      = BASE + {28'b0, off, 2'b00};
        dmWriteInput   = data;
        dmWriteEnabled = 1'b1;
        next_cycle();
        dmWriteEnabled = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit accepted);
        if (accepted) sb.push_back(b);
        store(2'd0, {24'hABCDEF, b});
    endtask

    task automatic check_reg(input string tag, input logic [1:0] off, input logic [31:0] exp);
        dmAddress      = BASE + {28'b0, off, 2'b00};
        dmWriteEnabled = 1'b0;
        #1;
        check_eq(tag, dmReadResult, exp);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 40 && sb.size() != 0; i++) next_cycle();
        next_cycle();
        check_eq(tag, 32'(sb.size()), 32'd0);
    endtask

    // Byte monitor: a handshake seen mid-cycle completes at the next rising edge.
    always @(negedge clock) begin
        if (!reset && txValid && txReady) begin
            if (sb.size() == 0) check_eq("tx_unexpected", {24'b0, txData}, 32'h0000_0100);
            else                check_eq("tx_byte", {24'b0, txData}, {24'b0, sb.pop_front()});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cyc_exp [3];
`ifdef MMIO_CONSOLE_CYCLE_EN
        cyc_exp[0] = 32'hFFFF_FFFE;
        cyc_exp[1] = 32'hFFFF_FFFF;
        cyc_exp[2] = 32'h0000_0000;
`else
        cyc_exp[0] = '0;
        cyc_exp[1] = '0;
        cyc_exp[2] = '0;
`endif
        reset          = 1'b1;
        dmAddress      = '0;
        dmWriteEnabled = 1'b0;
        dmWriteInput   = '0;
        txReady        = 1'b0;
        next_cycle();

        // Reset state and address decode.
        check_eq("rst_txvalid", {31'b0, txValid}, 32'd0);
        check_reg("rst_status", 2'd1, 32'h0000_000A);
        dmAddress = BASE + 32'd5;
        #1 check_eq("status_lowbits", dmReadResult, 32'h0000_000A);
        dmAddress = BASE - 32'd1;
        #1 check_eq("miss_below_hit", {31'b0, mmioHit}, 32'd0);
        check_eq("miss_below_data", dmReadResult, 32'd0);
        next_cycle();
        dmAddress = BASE + 32'd16;
        #1 check_eq("miss_above_hit", {31'b0, mmioHit}, 32'd0);
        dmAddress = BASE + 32'd15;
        #1 check_eq("top_hit", {31'b0, mmioHit}, 32'd1);
        check_eq("ctrl_rst", dmReadResult, 32'd1);
        reset = 1'b0;
        next_cycle();

        // Streaming three bytes with a ready sink.
        txReady = 1'b1;
        check_eq("no_bypass", {31'b0, txValid}, 32'd0);
        push_byte(8'h41, 1'b1);
        check_eq("first_valid", {31'b0, txValid}, 32'd1);
        check_eq("first_data", {24'b0, txData}, 32'h41);
        push_byte(8'h42, 1'b1);
        push_byte(8'h43, 1'b1);
        wait_drain("drain_abc");
        check_reg("status_idle", 2'd1, 32'h0000_000A);
        check_reg("txdata_read", 2'd0, 32'd0);

        // Fill past depth with a stalled sink: ninth byte dropped.
        txReady = 1'b0;
        for (int unsigned i = 0; i < 9; i++) push_byte(8'(i), i < 8);
        check_reg("status_ovf", 2'd1, 32'h0000_080D);
        check_eq("full_head", {24'b0, txData}, 32'h00);
        check_eq("full_valid", {31'b0, txValid}, 32'd1);

        // Clear overflow, then push into full FIFO while popping.
        store(2'd3, 32'h3);
        check_reg("status_clr", 2'd1, 32'h0000_0809);
        txReady = 1'b1;
        push_byte(8'h55, 1'b1);
        check_reg("status_pushpop", 2'd1, 32'h0000_0809);
        wait_drain("drain_full");
        check_reg("status_after_full", 2'd1, 32'h0000_000A);

        // Drain gating.
        store(2'd3, 32'h0);
        push_byte(8'h7E, 1'b1);
        check_eq("gated_valid", {31'b0, txValid}, 32'd0);
        check_reg("gated_status", 2'd1, 32'h0000_0100);
        next_cycle();
        next_cycle();
        check_eq("gated_hold", {31'b0, txValid}, 32'd0);
        check_reg("ctrl_off", 2'd3, 32'd0);
        store(2'd3, 32'h1);
        check_eq("ungated_valid", {31'b0, txValid}, 32'd1);
        check_eq("ungated_data", {24'b0, txData}, 32'h7E);
        wait_drain("drain_gated");

        // Cycle counter load and wrap.
        store(2'd2, 32'hFFFF_FFFE);
        check_reg("cycle0", 2'd2, cyc_exp[0]);
        next_cycle();
        check_reg("cycle1", 2'd2, cyc_exp[1]);
        next_cycle();
        check_reg("cycle2", 2'd2, cyc_exp[2]);

        // Asynchronous reset with bytes queued.
        txReady = 1'b0;
        for (int unsigned i = 0; i < 3; i++) push_byte(8'(8'hC0 + i), 1'b1);
        check_reg("status_three", 2'd1, 32'h0000_0308);
        check_eq("three_valid", {31'b0, txValid}, 32'd1);
        #1 reset = 1'b1;
        #1 check_eq("async_rst_valid", {31'b0, txValid}, 32'd0);
        sb.delete();
        next_cycle();
        next_cycle();
        reset = 1'b0;
        check_reg("post_rst_status", 2'd1, 32'h0000_000A);
        check_reg("post_rst_cycle", 2'd2, 32'd0);
        check_eq("post_rst_valid", {31'b0, txValid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
